// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment driver with frame-synchronous double
// buffering, leading-zero suppression and per-digit blanking.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      load,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic                      lz_suppress,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_done
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] EN_OFF =
        (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [DIV_W-1:0]        r_div_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_display;
    logic                    r_pending;
    logic                    r_frame_done;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_digit_en;

    logic                    w_tick;
    logic                    w_wrap;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [NUM_DIGITS-1:0]   w_upper_zero;
    logic [NUM_DIGITS-1:0]   w_blank_dig;
    logic                    w_blank;
    logic [3:0]              w_nibble;
    logic [6:0]              w_pattern;

    assign w_tick = (r_div_cnt == DIV_LAST);
    assign w_wrap = w_tick && (r_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
        end
    end

    // A load coinciding with the wrap goes straight to the display so it is
    // not held back a whole frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow  <= '0;
            r_display <= '0;
            r_pending <= 1'b0;
        end else begin
            if (load) begin
                r_shadow <= value;
            end
            if (w_wrap && load) begin
                r_display <= value;
                r_pending <= 1'b0;
            end else if (w_wrap && r_pending) begin
                r_display <= r_shadow;
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Per-digit select and blank terms; digit 0 is exempt from zero suppression.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_sel[gi]        = (r_idx == IDX_W'(gi));
            assign w_upper_zero[gi] = (r_display[4*NUM_DIGITS-1:4*gi] == '0);
            assign w_blank_dig[gi]  = blank_mask[gi] |
                                      (lz_suppress & (gi != 0) & w_upper_zero[gi]);
        end
    endgenerate

    assign w_blank = |(w_sel & w_blank_dig);

    always_comb begin
        w_nibble = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sel[i]) begin
                w_nibble = w_nibble | r_display[4*i +: 4];
            end
        end
    end

    always_comb begin
        w_pattern = 7'h00;
        case (w_nibble)
            4'h0: w_pattern = 7'h3F;
            4'h1: w_pattern = 7'h06;
            4'h2: w_pattern = 7'h5B;
            4'h3: w_pattern = 7'h4F;
            4'h4: w_pattern = 7'h66;
            4'h5: w_pattern = 7'h6D;
            4'h6: w_pattern = 7'h7D;
            4'h7: w_pattern = 7'h07;
            4'h8: w_pattern = 7'h7F;
            4'h9: w_pattern = 7'h6F;
            4'hA: w_pattern = 7'h77;
            4'hB: w_pattern = 7'h7C;
            4'hC: w_pattern = 7'h39;
            4'hD: w_pattern = 7'h5E;
            4'hE: w_pattern = 7'h79;
            4'hF: w_pattern = 7'h71;
            default: w_pattern = 7'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg      <= SEG_OFF;
            r_digit_en <= EN_OFF;
        end else begin
            if (w_blank) begin
                r_seg <= SEG_OFF;
            end else begin
                r_seg <= (ACTIVE_LOW != 0) ? ~w_pattern : w_pattern;
            end
            r_digit_en <= (ACTIVE_LOW != 0) ? ~w_sel : w_sel;
        end
    end

    assign seg        = r_seg;
    assign digit_en   = r_digit_en;
    assign frame_done = r_frame_done;
endmodule
